// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus port as seen by the UART/halt MMIO block.
// The master drives requests, and the slave returns registered read data.
interface mmio_uart_tx_if;
  logic [31:0] mem_addr;
  logic        mem_oe;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    output mem_addr, mem_oe, mem_wdata, mem_we,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_addr, mem_oe, mem_wdata, mem_we,
    output mem_rdata, mem_valid
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: byte FIFO feeding an 8N1 serialiser, status reads,
// and the sticky halt register used by synthesis builds in place of $finish.
module mmio_uart_tx #(
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned FIFO_LOG  = 4,
  parameter logic [31:0] BASE      = 32'hf0000100,
  parameter logic [31:0] HALT_ADDR = 32'hf0000000
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_uart_tx_if.slave        bus,
  output logic                 txd,
  output logic                 halt,
  output logic [31:0]          halt_code
);

  localparam int unsigned          Depth    = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0]    DepthCnt = Depth[FIFO_LOG:0];
  localparam logic [FIFO_LOG:0]    PtrOne   = 1;
  localparam logic [15:0]          BaudLast = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [FIFO_LOG:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]           fifo_q [Depth];
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 halt_q, halt_d;
  logic [31:0]          code_q, code_d;

  logic                 is_wr, is_rd, hit_base, hit_stat, hit_halt;
  logic [FIFO_LOG:0]    count;
  logic                 full, empty, push, drop, pop, busy;

  assign is_wr    = bus.mem_oe & bus.mem_we[0];
  assign is_rd    = bus.mem_oe & (bus.mem_we == 4'b0000);
  assign hit_base = (bus.mem_addr == BASE);
  assign hit_stat = (bus.mem_addr == BASE + 32'd4);
  assign hit_halt = (bus.mem_addr == HALT_ADDR);

  // Full is judged on the pre-edge count, so a same-cycle pop cannot rescue a write.
  assign count = wptr_q - rptr_q;
  assign full  = (count == DepthCnt);
  assign empty = (count == '0);
  assign push  = is_wr & hit_base & ~full;
  assign drop  = is_wr & hit_base & full;
  assign busy  = (state_q != StIdle);

  assign wptr_d = push ? wptr_q + PtrOne : wptr_q;
  assign rptr_d = pop  ? rptr_q + PtrOne : rptr_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rptr_q[FIFO_LOG-1:0]];
          baud_d  = BaudLast;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == 16'd0) begin
          baud_d  = BaudLast;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (baud_q == 16'd0) begin
          baud_d  = BaudLast;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StStop: begin
        if (baud_q == 16'd0) begin
          if (!empty) begin
            // Back-to-back frames: next start bit follows the stop bit directly.
            pop     = 1'b1;
            shift_d = fifo_q[rptr_q[FIFO_LOG-1:0]];
            baud_d  = BaudLast;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    rdata_d = 32'd0;
    if (is_rd && hit_base) begin
      valid_d = 1'b1;
      rdata_d = {31'd0, ~full};
    end else if (is_rd && hit_stat) begin
      valid_d = 1'b1;
      rdata_d = {busy, ovf_q, 22'd0, 8'(count)};
    end else if (is_rd && hit_halt) begin
      valid_d = 1'b1;
      rdata_d = {31'd0, halt_q};
    end
  end

  // A status read clears ovf, but an overflow in the same cycle wins.
  assign ovf_d  = (ovf_q & ~(is_rd & hit_stat)) | drop;
  assign halt_d = halt_q | (is_wr & hit_halt);
  assign code_d = (is_wr & hit_halt & ~halt_q) ? bus.mem_wdata : code_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      halt_q  <= 1'b0;
      code_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      halt_q  <= halt_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) fifo_q[wptr_q[FIFO_LOG-1:0]] <= bus.mem_wdata[7:0];
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_rdata = rdata_q;
  assign halt          = halt_q;
  assign halt_code     = code_q;

endmodule
